// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard/sequencing controller: tracks X/M/W destination tags,
// builds the forwarding vector, stalls on non-forwardable hazards, kills
// decode on redirect and drains/parks the pipe after HALT.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        Valid_D,
    input  logic        Read1_used,
    input  logic        Read2_used,
    input  logic [2:0]  Read1_sel,
    input  logic [2:0]  Read2_sel,
    input  logic [2:0]  Rd_sel_D,
    input  logic        RegWrite_D,
    input  logic        MemRead_D,
    input  logic        ValidFwd_D,
    input  logic        Halt_D,
    input  logic        Redirect_X,
    output logic        Stall_F,
    output logic        Bubble_X,
    output logic        Flush_D,
    output logic [11:0] Forwarding_vector,
    output logic        Halted
);

    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       ld;
        logic       fwd;
    } tag_t;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    tag_t       tag_x, tag_m, tag_w, tag_x_nxt;
    logic       haz, accept, halt_go;

    // X entry whose value is not yet available (load, or non-forwardable) and is read by decode
    always_comb begin
        haz = Valid_D & tag_x.v & (tag_x.ld | ~tag_x.fwd) &
              ((Read1_used & (Read1_sel == tag_x.rd)) |
               (Read2_used & (Read2_sel == tag_x.rd)));
    end

    // Control outputs, decode acceptance and next state; redirect wins over stall
    always_comb begin
        Stall_F   = 1'b1;
        Bubble_X  = 1'b1;
        Flush_D   = 1'b0;
        accept    = 1'b0;
        halt_go   = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        tag_x_nxt = '0;
        case (state)
            S_RUN: begin
                Stall_F  = haz & ~Redirect_X;
                Flush_D  = Redirect_X;
                Bubble_X = haz | Redirect_X;
                accept   = Valid_D & RegWrite_D & ~Stall_F & ~Flush_D;
                halt_go  = Valid_D & Halt_D & ~Stall_F & ~Flush_D;
                if (halt_go) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = 2'd0;
                end
            end
            S_DRAIN: begin
                cnt_nxt = cnt + 2'd1;
                if (cnt == 2'd2) state_nxt = S_HALTED;
            end
            default: state_nxt = S_HALTED;
        endcase
        // Bubbles carry an all-zero tag so drained fields read back as zero
        if (accept) tag_x_nxt = '{v: 1'b1, rd: Rd_sel_D, ld: MemRead_D, fwd: ValidFwd_D};
    end

    // Tag pipe advances every cycle; state and drain counter registered alongside
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_RUN;
            cnt   <= 2'd0;
            tag_x <= '0;
            tag_m <= '0;
            tag_w <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tag_x <= tag_x_nxt;
            tag_m <= tag_x;
            tag_w <= tag_m;
        end
    end

    // X result is only forwardable once it is a computed (non-load) value
    assign Forwarding_vector = {tag_w.v, tag_w.rd,
                                tag_m.v, tag_m.rd,
                                tag_x.v & tag_x.fwd & ~tag_x.ld, tag_x.rd};
    assign Halted = (state == S_HALTED);

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the decode stage. Tracks destination-register tags of instructions in execute (X), memory (M) and writeback (W). From those tags it produces the 12-bit `Forwarding_vector` consumed by decode, and it stalls fetch/decode on load-use and non-forwardable hazards. It also kills the decode-stage instruction on a taken branch/jump resolved in execute, and drains the pipe and parks the processor after a `HALT`.

## Interface
No parameters.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low (0 = reset, sampled on rising `clk`)
- `Valid_D`  in  1  decode holds a valid instruction
- `Read1_used`  in  1  decode instruction reads Rs
- `Read2_used`  in  1  decode instruction reads Rt
- `Read1_sel`  in  3  Rs index (`Instruction[10:8]`)
- `Read2_sel`  in  3  Rt index (`Instruction[7:5]`)
- `Rd_sel_D`  in  3  decode write-register select
- `RegWrite_D`  in  1  decode instruction writes a register
- `MemRead_D`  in  1  decode instruction is a load
- `ValidFwd_D`  in  1  decode result is forwardable from X
- `Halt_D`  in  1  decode instruction is `HALT`
- `Redirect_X`  in  1  execute resolved a taken branch/jump this cycle
- `Stall_F`  out  1  hold PC and IF/ID register
- `Bubble_X`  out  1  load NOP into ID/EX
- `Flush_D`  out  1  invalidate IF/ID contents
- `Forwarding_vector`  out  12  `{W.v,W.rd, M.v,M.rd, X.v,X.rd}`; bit 3 = X valid, [2:0] = X rd
- `Halted`  out  1  processor parked

## Operation
- Tag pipe: three registered entries X, M, W. Each entry holds `{v, rd[2:0], ld, fwd}`.
- Advance every cycle: W<=M, M<=X. The pipe never freezes; stalls insert bubbles.
- X load: X <= `{1, Rd_sel_D, MemRead_D, ValidFwd_D}` only when `accept = Valid_D & RegWrite_D & ~Stall_F & ~Flush_D` and state is RUN. Otherwise X.v <= 0.
- `Forwarding_vector` fields:
  - X field valid = `X.v & X.fwd & ~X.ld`.
  - M field valid = `M.v`.
  - W field valid = `W.v`.
  - rd fields are always driven with the entry's rd.
- Hazard `haz` = `Valid_D & X.v & (X.ld | ~X.fwd) & ((Read1_used & Read1_sel==X.rd) | (Read2_used & Read2_sel==X.rd))`.
- Stall: `Stall_F = Bubble_X = haz & ~Redirect_X` while in RUN.
  - A hazard lasts exactly one cycle, because the offending entry moves to M where it is forwarded.
- Redirect: `Flush_D = Redirect_X` in RUN. Redirect beats stall. The killed decode instruction is never loaded into X. `Bubble_X` = 1 on that cycle.
- States:
  - RUN → DRAIN when `Valid_D & Halt_D & ~Stall_F & ~Flush_D`.
  - DRAIN: `Stall_F = Bubble_X = 1`, `Flush_D = 0`, and `Redirect_X` is ignored. A 2-bit counter loads 0 on entry and increments each cycle. DRAIN → HALTED when the counter is 2 (3 DRAIN cycles).
  - HALTED: `Stall_F = Bubble_X = 1`, `Halted = 1`, and all tags are invalid. The state is left only by reset.
- Halt blocked by a hazard is accepted on the first non-stalled cycle.
- `rd` = 7 is treated like any other register; there is no r0 special case.

## Timing
- Reset:
  - All tags cleared to v = 0, state RUN, counter 0.
  - `Forwarding_vector` = 12'h000.
  - `Stall_F`, `Bubble_X`, `Flush_D` and `Halted` all 0.
  - Reset mid-DRAIN or mid-HALTED returns to RUN next cycle.
- `Forwarding_vector` and `Halted` are pure functions of registers and are valid from the start of the cycle.
- `Stall_F`, `Bubble_X` and `Flush_D` are combinational from current inputs and registers, settled within the same cycle.
- Tag latency: an instruction accepted at edge n is X in cycle n+1, M in n+2, W in n+3, and gone in n+4.
- Load-use sequence: load accepted at n. The dependent instruction stalls in cycle n+1. The load tag is forwarded from M in cycle n+2, when the dependent instruction is accepted.
- A simultaneous hazard and redirect gives `Flush_D` = 1 and `Stall_F` = 0.

## Test plan
- Reset, then `ADD` with rd=3 and `fwd`=1 accepted: `Forwarding_vector` reads 12'h00B one cycle after accept, 12'h0B0 after two cycles, 12'hB00 after three, and 12'h000 after four.
- Load to r5 followed by an instruction reading Rs=5: `Stall_F`=`Bubble_X`=1 for exactly one cycle. Next cycle M field = {1,5} and the dependent instruction is accepted.
- Load to r5 followed by an instruction reading only Rt=2: no stall.
- `Redirect_X`=1 while decode holds a hazarding instruction: `Flush_D`=1, `Stall_F`=0. X is invalid next cycle and the X field of `Forwarding_vector` is 0.
- `HALT` accepted at cycle n: `Stall_F`=1 for cycles n+1..n+3 with `Redirect_X` pulsed during them and ignored. `Halted`=1 from n+4 onward and `Forwarding_vector`=12'h000.
- `rst`=0 driven during DRAIN: the next cycle shows all outputs 0 and the state is RUN. A fresh instruction is accepted normally.
